// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port integer register file.
// Write port indices also fix write priority: the higher index wins.
package regfile_pkg;
  localparam int XLEN_DEFAULT = 32;
  localparam int NREG_DEFAULT = 32;
  localparam int REG_ZERO = 0;
  localparam int WP_ALU = 0;
  localparam int WP_MEM = 1;
  localparam int NWP = 2;
  typedef logic [XLEN_DEFAULT-1:0] xlen_t;
endpackage

// File: rtl/register_file_mp_if.sv
// Decode/writeback bundle of the register file: reads, writes, issue.
// master = pipeline side, slave = register file side.
interface register_file_mp_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2
);
  localparam int AW = $clog2(NREG);

  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD*XLEN-1:0] rs_dout;
  logic [NRD-1:0]      rs_busy;
  logic                we0;
  logic [AW-1:0]       rd0_addr;
  logic [XLEN-1:0]     rd0_din;
  logic                we1;
  logic [AW-1:0]       rd1_addr;
  logic [XLEN-1:0]     rd1_din;
  logic                issue_valid;
  logic [AW-1:0]       issue_addr;
  logic                any_busy;

  modport master (
    output rs_addr, we0, rd0_addr, rd0_din,
    output we1, rd1_addr, rd1_din,
    output issue_valid, issue_addr,
    input  rs_dout, rs_busy, any_busy
  );

  modport slave (
    input  rs_addr, we0, rd0_addr, rd0_din,
    input  we1, rd1_addr, rd1_din,
    input  issue_valid, issue_addr,
    output rs_dout, rs_busy, any_busy
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write bit per register for RAW stalls on long-latency producers.
// A new issue on the same edge as a completing write keeps the bit set.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = NREG_DEFAULT,
  parameter int AW   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NWP-1:0]    wr_en_i,
  input  logic [NWP*AW-1:0] wr_addr_i,
  input  logic              issue_valid_i,
  input  logic [AW-1:0]     issue_addr_i,
  output logic [NREG-1:0]   pending_o,
  output logic              any_busy_o
);
  logic [NREG-1:0] pend_q, pend_d;
  logic [NREG-1:0] set_v, clr_v;

  always_comb begin
    set_v = '0;
    clr_v = '0;
    if (issue_valid_i) set_v[issue_addr_i] = 1'b1;
    for (int w = 0; w < NWP; w++)
      if (wr_en_i[w]) clr_v[wr_addr_i[w*AW +: AW]] = 1'b1;
    pend_d = set_v | (pend_q & ~clr_v);
    pend_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  assign pending_o  = pend_q;
  assign any_busy_o = |pend_q;
endmodule

// File: rtl/register_file_mp.sv
// Integer register file: NRD read ports, two prioritised write ports.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int NREG = NREG_DEFAULT,
  parameter int NRD  = 2,
  parameter int AW   = $clog2(NREG)
) (
  input logic clk,
  input logic rst,
  register_file_mp_if.slave bus
);
  logic [NWP-1:0]           wen;
  logic [NWP-1:0][AW-1:0]   waddr;
  logic [NWP-1:0][XLEN-1:0] wdata;
  logic [NREG-1:0]          pending;
  logic                     any_busy_w;
  logic [XLEN-1:0]          regs_q [NREG];
  logic [XLEN-1:0]          regs_d [NREG];
  logic [NRD*XLEN-1:0]      dout_w;
  logic [NRD-1:0]           busy_w;
  logic [AW-1:0]            ra;
  logic [XLEN-1:0]          rv;
  logic                     rb;

  assign waddr[WP_ALU] = bus.rd0_addr;
  assign waddr[WP_MEM] = bus.rd1_addr;
  assign wdata[WP_ALU] = bus.rd0_din;
  assign wdata[WP_MEM] = bus.rd1_din;
  assign wen[WP_ALU] = bus.we0 && (bus.rd0_addr != AW'(REG_ZERO));
  assign wen[WP_MEM] = bus.we1 && (bus.rd1_addr != AW'(REG_ZERO));

  regfile_scoreboard #(.NREG(NREG), .AW(AW)) u_sb (
    .clk          (clk),
    .rst          (rst),
    .wr_en_i      (wen),
    .wr_addr_i    (waddr),
    .issue_valid_i(bus.issue_valid && (bus.issue_addr != AW'(REG_ZERO))),
    .issue_addr_i (bus.issue_addr),
    .pending_o    (pending),
    .any_busy_o   (any_busy_w)
  );

  // Ascending port order lets the memory port win a collision.
  always_comb begin
    regs_d = regs_q;
    for (int w = 0; w < NWP; w++)
      if (wen[w]) regs_d[waddr[w]] = wdata[w];
    regs_d[REG_ZERO] = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    dout_w = '0;
    busy_w = '0;
    ra = '0;
    rv = '0;
    rb = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      ra = bus.rs_addr[p*AW +: AW];
      rv = '0;
      rb = 1'b0;
      if (!rst && ra != AW'(REG_ZERO)) begin
        rv = regs_q[ra];
        rb = pending[ra];
`ifdef REGFILE_BYPASS_EN
        for (int w = 0; w < NWP; w++) begin
          if (wen[w] && waddr[w] == ra) begin
            rv = wdata[w];
            rb = rb && bus.issue_valid
                 && (bus.issue_addr == ra);
          end
        end
`endif
      end
      dout_w[p*XLEN +: XLEN] = rv;
      busy_w[p] = rb;
    end
  end

  assign bus.rs_dout  = dout_w;
  assign bus.rs_busy  = busy_w;
  assign bus.any_busy = any_busy_w;
endmodule

// File: tb/tb_register_file_mp.sv
// Randomised scoreboard bench for register_file_mp.
// Build with REGFILE_BYPASS_EN to check the forwarding variant.
module tb_register_file_mp;
  import regfile_pkg::*;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 3;
  localparam int AW   = $clog2(NREG);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  register_file_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) bus();

  register_file_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic [NRD*XLEN-1:0] dout;
    logic [NRD-1:0]      busy;
    logic                any;
    int                  tag;
  } exp_t;

  exp_t            q[$];
  logic [XLEN-1:0] m_reg [NREG];
  bit              m_pend [NREG];
  int              tests = 0;
  int              fails = 0;

  task automatic chk(input string nm, input int tag,
                     input logic [XLEN-1:0] act,
                     input logic [XLEN-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s tag=%0d got=%h want=%h", nm, tag, act, exp);
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      for (int p = 0; p < NRD; p++) begin
        chk("rs_dout", e.tag, bus.rs_dout[p*XLEN +: XLEN],
            e.dout[p*XLEN +: XLEN]);
        chk("rs_busy", e.tag, XLEN'(bus.rs_busy[p]),
            XLEN'(e.busy[p]));
      end
      chk("any_busy", e.tag, XLEN'(bus.any_busy), XLEN'(e.any));
    end
  end

  function automatic logic [NRD*AW-1:0] rd3(input int a, input int b,
                                            input int c);
    return {AW'(c), AW'(b), AW'(a)};
  endfunction

  task automatic model_clear();
    for (int r = 0; r < NREG; r++) begin
      m_reg[r] = '0;
      m_pend[r] = 1'b0;
    end
  endtask

  // Drive one cycle of stimulus, push the expected read view, then
  // advance the architectural model to the state after the next edge.
  task automatic apply(input bit w0, input int a0, input logic [XLEN-1:0] d0,
                       input bit w1, input int a1, input logic [XLEN-1:0] d1,
                       input bit iv, input int ia,
                       input logic [NRD*AW-1:0] ra, input int tag);
    exp_t e;
    int a;
    bus.we0 = w0; bus.rd0_addr = AW'(a0); bus.rd0_din = d0;
    bus.we1 = w1; bus.rd1_addr = AW'(a1); bus.rd1_din = d1;
    bus.issue_valid = iv; bus.issue_addr = AW'(ia);
    bus.rs_addr = ra;
    e.tag = tag; e.any = 1'b0; e.dout = '0; e.busy = '0;
    for (int r = 0; r < NREG; r++) e.any = e.any | m_pend[r];
    for (int p = 0; p < NRD; p++) begin
      a = int'(ra[p*AW +: AW]);
      if (a != 0) begin
        e.dout[p*XLEN +: XLEN] = m_reg[a];
        e.busy[p] = m_pend[a];
`ifdef REGFILE_BYPASS_EN
        if ((w1 && a1 == a) || (w0 && a0 == a)) begin
          e.dout[p*XLEN +: XLEN] = (w1 && a1 == a) ? d1 : d0;
          if (!(iv && ia == a)) e.busy[p] = 1'b0;
        end
`endif
      end
    end
    q.push_back(e);
    if (w0 && a0 != 0) begin m_reg[a0] = d0; m_pend[a0] = 1'b0; end
    if (w1 && a1 != 0) begin m_reg[a1] = d1; m_pend[a1] = 1'b0; end
    if (iv && ia != 0) m_pend[ia] = 1'b1;
  endtask

  task automatic rd_only(input logic [NRD*AW-1:0] ra, input int tag);
    apply(0, 0, '0, 0, 0, '0, 0, 0, ra, tag);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_view(input int tag);
    for (int p = 0; p < NRD; p++) begin
      chk("rst_dout", tag, bus.rs_dout[p*XLEN +: XLEN], '0);
      chk("rst_busy", tag, XLEN'(bus.rs_busy[p]), '0);
    end
    chk("rst_any", tag, XLEN'(bus.any_busy), '0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    model_clear();
    bus.we0 = 0; bus.rd0_addr = '0; bus.rd0_din = '0;
    bus.we1 = 0; bus.rd1_addr = '0; bus.rd1_din = '0;
    bus.issue_valid = 0; bus.issue_addr = '0;
    bus.rs_addr = rd3(5, 1, 31);
    #2;
    chk_reset_view(0);
    step();
    rst = 1'b0;

    // x5 written and issued, then reset lands mid-cycle over a new write
    apply(1, 5, 32'hDEADBEEF, 0, 0, '0, 1, 5, rd3(5, 0, 0), 1);
    step();
    rd_only(rd3(5, 5, 0), 2);
    step();
    apply(1, 5, 32'h55555555, 0, 0, '0, 1, 6, rd3(5, 6, 0), 3);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_reset_view(4);
    model_clear();
    step();
    rst = 1'b0;
    rd_only(rd3(5, 6, 0), 5);
    step();

    // dual write
    apply(1, 3, 32'h11111111, 1, 4, 32'h22222222, 0, 0, rd3(3, 4, 0), 6);
    step();
    rd_only(rd3(3, 4, 0), 7);
    step();

    // collision on x7
    apply(1, 7, 32'hAAAA0000, 1, 7, 32'h0000BBBB, 0, 0, rd3(7, 0, 3), 8);
    step();
    rd_only(rd3(7, 7, 4), 9);
    step();

    // zero register through both ports and issue
    apply(1, 0, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 1, 0, rd3(0, 0, 0), 10);
    step();
    rd_only(rd3(0, 0, 7), 11);
    step();

    // scoreboard sequence on x9
    apply(0, 0, '0, 0, 0, '0, 1, 9, rd3(9, 0, 0), 12);
    step();
    rd_only(rd3(9, 9, 0), 13);
    step();
    apply(0, 0, '0, 1, 9, 32'h99999999, 0, 0, rd3(9, 0, 0), 14);
    step();
    rd_only(rd3(9, 0, 9), 15);
    step();
    apply(1, 9, 32'h09090909, 0, 0, '0, 1, 9, rd3(9, 0, 0), 16);
    step();
    rd_only(rd3(9, 9, 9), 17);
    step();

    // write-then-read on x12, with and without forwarding
    apply(1, 12, 32'hCAFEF00D, 0, 0, '0, 0, 0, rd3(0, 0, 0), 18);
    step();
    apply(1, 12, 32'h12345678, 0, 0, '0, 0, 0, rd3(12, 0, 0), 19);
    step();
    rd_only(rd3(12, 12, 0), 20);
    step();

    // randomised traffic over a small address pool to force collisions
    for (int i = 0; i < 400; i++) begin
      apply($urandom_range(0, 1) == 1, int'($urandom_range(0, 15)), $urandom,
            $urandom_range(0, 1) == 1, int'($urandom_range(0, 15)), $urandom,
            $urandom_range(0, 3) == 0, int'($urandom_range(0, 15)),
            rd3(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 15))),
            100 + i);
      step();
    end
    rd_only(rd3(1, 2, 3), 600);
    step();

    n = 0;
    while (q.size() > 0 && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    tests++;
    if (q.size() > 0) begin
      fails++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised successor to the single-write, two-read integer register file.
- Provides NRD combinational read ports, two synchronous write ports with fixed priority, and a hardwired-zero register 0.
- Includes a per-register pending-write scoreboard, so the decode stage can stall on RAW hazards from multi-cycle producers such as loads and the divider.
- Sits between decode (reads, issue) and the writeback stages (write port 0 = ALU writeback, port 1 = memory/long-latency writeback).

Parameters:
XLEN, 32, data width in bits
NREG, 32, number of architectural registers (power of two, >=2)
NRD, 2, number of read ports (1..4)
AW, $clog2(NREG), address width (derived; do not override)

Ports:
clk  input  1  clock, rising-edge active
rst  input  1  reset, asynchronous, active-high
rs_addr  input  NRD*AW  read addresses, port i at [i*AW +: AW]
rs_dout  output  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
rs_busy  output  NRD  1 = addressed register has a pending write
we0  input  1  write enable, port 0
rd0_addr  input  AW  write address, port 0
rd0_din  input  XLEN  write data, port 0
we1  input  1  write enable, port 1
rd1_addr  input  AW  write address, port 1
rd1_din  input  XLEN  write data, port 1
issue_valid  input  1  marks issue_addr as pending from next edge
issue_addr  input  AW  destination of the issuing long-latency instruction
any_busy  output  1  OR of all pending bits

Behaviour:
- Reset: asynchronous on rst high.
  - All registers cleared to 0; all pending bits cleared.
  - rs_dout, rs_busy and any_busy are 0 while rst is high.
- Reads: combinational.
  - rs_dout[i] = reg[rs_addr[i]].
  - Address 0 always reads 0 and rs_busy = 0.
- Writes: on the rising edge of clk when weN=1 and rdN_addr != 0.
  - Writes to address 0 are ignored.
  - Both ports may write different registers in the same cycle.
  - Same-address collision: port 1 data wins.
- Scoreboard: one pending bit per register; bit 0 is tied to 0.
  - Set: on the edge where issue_valid=1 and issue_addr != 0.
  - Clear: on the edge where any write port writes that address.
  - Same-edge set and clear on the same register: set wins, because the new producer supersedes the completed one.
  - Setting an already-pending bit is legal and has no effect (no counting).
- rs_busy[i] = pending[rs_addr[i]].
- any_busy = |pending.
- Latency:
  - A write is visible on reads the cycle after the edge.
  - A pending bit is visible on rs_busy the cycle after issue.
- Reset asserted mid-operation discards in-flight writes on that edge; pending bits clear immediately.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding.
  - If rs_addr[i] != 0 matches an active write this cycle, rs_dout[i] returns that write's data (port 1 over port 0 on a double match).
  - rs_busy[i] is forced to 0 in that case unless issue_valid targets the same address in that cycle.
  - Net effect: zero-cycle write-to-read latency.
- Undefined: reads return the stored value until after the edge; the pipeline must insert one bubble.
- Port list is identical in both builds.

Decomposition:
- Shared package regfile_pkg holds:
  - XLEN_DEFAULT=32, NREG_DEFAULT=32, REG_ZERO=0;
  - the typedef xlen_t;
  - the write-port index constants WP_ALU=0 and WP_MEM=1.
- Sub-module regfile_scoreboard holds the NREG pending-bit array, its set/clear/priority logic and the any_busy reduction.
- Storage and read muxes stay in the top module.

Test Plan:
- Reset: write 0xDEADBEEF to x5, assert rst mid-cycle -> rs_dout for x5 = 0 immediately; any_busy = 0.
- Dual write: we0 x3=0x11111111 and we1 x4=0x22222222 on one edge -> next cycle x3 = 0x11111111 and x4 = 0x22222222.
- Collision: we0 and we1 both to x7, with 0xAAAA0000 and 0x0000BBBB -> x7 = 0x0000BBBB.
- Zero register: write 0xFFFFFFFF to x0 via both ports, and issue x0 -> reads 0, rs_busy = 0.
- Scoreboard sequence on x9 -> rs_busy = 1 the following cycle.
  - Then write x9 via we1 -> rs_busy = 0 the next cycle.
  - Then issue x9 and write x9 on the same edge -> rs_busy stays 1.
- Bypass (REGFILE_BYPASS_EN defined): read x12 while we0 writes 0x12345678 to x12 -> rs_dout = 0x12345678 in the same cycle.
  - Same stimulus without the macro -> old value in that cycle, 0x12345678 in the next.
